// File: rtl/synchronous_fifo.sv
// ---------------------------------------------------------------------------
// synchronous_fifo
//
// Single-clock FIFO with a registered read port. Storage is a plain register
// array indexed by the low bits of two (log2(FIFO_DEPTH)+1)-bit pointers; the
// extra pointer MSB tells "full" apart from "empty" when the low bits match.
//
// Optional feature macro: SYNC_FIFO_ERR_FLAGS_EN
//   When defined, the block adds registered one-cycle pulse outputs
//   'overflow' (write attempted while full) and 'underflow' (read attempted
//   while empty). When undefined, those ports and their logic do not exist.
//
// Reset is asynchronous and active-low. It clears the pointers and data_out
// only; storage contents are left alone and become unreachable because the
// pointers say the FIFO is empty.
// ---------------------------------------------------------------------------
module synchronous_fifo #(
    parameter int FIFO_DEPTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cs,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  empty,
    output logic                  full
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    ,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    // Address width for the storage array; pointers carry one extra wrap bit.
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    // Storage: no reset on purpose, stale words are hidden by the pointers.
    logic [DATA_WIDTH-1:0] memArray_q [FIFO_DEPTH];

    logic [AW:0]           wrPtr_q;
    logic [AW:0]           wrPtr_d;
    logic [AW:0]           rdPtr_q;
    logic [AW:0]           rdPtr_d;
    logic [DATA_WIDTH-1:0] dataOut_q;
    logic [DATA_WIDTH-1:0] dataOut_d;

    logic                  emptyFlag;
    logic                  fullFlag;
    logic                  wrAccept;
    logic                  rdAccept;
    logic [AW-1:0]         wrAddr;
    logic [AW-1:0]         rdAddr;

    // Status flags come straight from the current pointers, so they reflect
    // reset immediately and are what both request paths use for this edge.
    always_comb begin
        emptyFlag = (wrPtr_q == rdPtr_q);
        fullFlag  = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                    (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    end

    // Qualify requests: chip select gates both, and each side is judged
    // independently against the pre-edge flags.
    always_comb begin
        wrAccept = cs && wr_en && !fullFlag;
        rdAccept = cs && rd_en && !emptyFlag;
        wrAddr   = wrPtr_q[AW-1:0];
        rdAddr   = rdPtr_q[AW-1:0];
    end

    // Next-state for pointers and the output register; everything holds
    // unless its side of the transfer is accepted.
    always_comb begin
        wrPtr_d   = wrPtr_q;
        rdPtr_d   = rdPtr_q;
        dataOut_d = dataOut_q;
        if (wrAccept) begin
            wrPtr_d = wrPtr_q + PTR_ONE;
        end
        if (rdAccept) begin
            rdPtr_d   = rdPtr_q + PTR_ONE;
            dataOut_d = memArray_q[rdAddr];
        end
    end

    // Pointer and read-data registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            dataOut_q <= '0;
        end else begin
            wrPtr_q   <= wrPtr_d;
            rdPtr_q   <= rdPtr_d;
            dataOut_q <= dataOut_d;
        end
    end

    // Storage write port; only an accepted write touches the array.
    always_ff @(posedge clk) begin
        if (wrAccept) begin
            memArray_q[wrAddr] <= data_in;
        end
    end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic overflow_q;
    logic overflow_d;
    logic underflow_q;
    logic underflow_d;

    // Error pulses flag a rejected request; chip select must be high for a
    // request to count as an attempt at all.
    always_comb begin
        overflow_d  = cs && wr_en && fullFlag;
        underflow_d = cs && rd_en && emptyFlag;
    end

    // Error pulse registers, each high for exactly the cycle after the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

    assign data_out = dataOut_q;
    assign empty    = emptyFlag;
    assign full     = fullFlag;

endmodule

// File: tb/tb_synchronous_fifo.sv
// ---------------------------------------------------------------------------
// tb_synchronous_fifo
//
// Directed bench for synchronous_fifo (FIFO_DEPTH=8, DATA_WIDTH=32).
// A table of single-cycle vectors covers basic ordering, empty reads, chip
// select gating and a write/read collision on an empty FIFO; hand-written
// sequences cover ping-pong, overflow, pointer wrap with simultaneous access
// and asynchronous reset in the middle of operation.
// ---------------------------------------------------------------------------
module tb_synchronous_fifo;

    localparam int DEPTH = 8;
    localparam int WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic             cs;
    logic             wr_en;
    logic             rd_en;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             empty;
    logic             full;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic             overflow;
    logic             underflow;
`endif

    int checkCount;
    int passCount;

    typedef struct {
        string       name;
        logic        cs;
        logic        wr;
        logic        rd;
        logic [31:0] din;
        logic [31:0] expDout;
        logic        expEmpty;
        logic        expFull;
    } vec_t;

    vec_t vecs [12];

    synchronous_fifo #(
        .FIFO_DEPTH(DEPTH),
        .DATA_WIDTH(WIDTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cs       (cs),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .data_in  (data_in),
        .data_out (data_out),
        .empty    (empty),
        .full     (full)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        ,
        .overflow (overflow),
        .underflow(underflow)
`endif
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkValue(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: actual 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, then settle after the
    // following rising edge so outputs are sampled away from the clock.
    task automatic applyStimulus(input logic c, input logic w, input logic r,
                                 input logic [31:0] d);
        @(negedge clk);
        cs      = c;
        wr_en   = w;
        rd_en   = r;
        data_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] expDout,
                               input logic expEmpty, input logic expFull);
        checkValue({name, ".data_out"}, data_out, expDout);
        checkValue({name, ".empty"}, {31'b0, empty}, {31'b0, expEmpty});
        checkValue({name, ".full"}, {31'b0, full}, {31'b0, expFull});
    endtask

    initial begin
        logic [31:0] expWord;

        checkCount = 0;
        passCount  = 0;
        rst_n      = 1'b0;
        cs         = 1'b0;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        data_in    = '0;

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        checkOutput("reset_hold", 32'd0, 1'b1, 1'b0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        checkValue("reset_hold.overflow", {31'b0, overflow}, 32'd0);
        checkValue("reset_hold.underflow", {31'b0, underflow}, 32'd0);
`endif
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF);
        checkOutput("reset_release_idle", 32'd0, 1'b1, 1'b0);

        // ---------------- table-driven vectors ----------------
        vecs[0]  = '{"wr_1",          1'b1, 1'b1, 1'b0, 32'd1,   32'd0,   1'b0, 1'b0};
        vecs[1]  = '{"wr_10",         1'b1, 1'b1, 1'b0, 32'd10,  32'd0,   1'b0, 1'b0};
        vecs[2]  = '{"wr_100",        1'b1, 1'b1, 1'b0, 32'd100, 32'd0,   1'b0, 1'b0};
        vecs[3]  = '{"rd_1",          1'b1, 1'b0, 1'b1, 32'd0,   32'd1,   1'b0, 1'b0};
        vecs[4]  = '{"rd_10",         1'b1, 1'b0, 1'b1, 32'd0,   32'd10,  1'b0, 1'b0};
        vecs[5]  = '{"rd_100",        1'b1, 1'b0, 1'b1, 32'd0,   32'd100, 1'b1, 1'b0};
        vecs[6]  = '{"rd_empty",      1'b1, 1'b0, 1'b1, 32'd0,   32'd100, 1'b1, 1'b0};
        vecs[7]  = '{"wr_cs0",        1'b0, 1'b1, 1'b0, 32'd55,  32'd100, 1'b1, 1'b0};
        vecs[8]  = '{"rd_cs0",        1'b0, 1'b0, 1'b1, 32'd0,   32'd100, 1'b1, 1'b0};
        vecs[9]  = '{"wr_rd_empty",   1'b1, 1'b1, 1'b1, 32'd7,   32'd100, 1'b0, 1'b0};
        vecs[10] = '{"idle_one",      1'b1, 1'b0, 1'b0, 32'd9,   32'd100, 1'b0, 1'b0};
        vecs[11] = '{"rd_7",          1'b1, 1'b0, 1'b1, 32'd0,   32'd7,   1'b1, 1'b0};

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].cs, vecs[i].wr, vecs[i].rd, vecs[i].din);
            checkOutput(vecs[i].name, vecs[i].expDout, vecs[i].expEmpty, vecs[i].expFull);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
            if (i == 6) begin
                checkValue("rd_empty.underflow", {31'b0, underflow}, 32'd1);
            end
            if (i == 7) begin
                checkValue("after_rd_empty.underflow", {31'b0, underflow}, 32'd0);
            end
`endif
        end

        // ---------------- ping-pong ----------------
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 32'd1 << i);
            checkValue($sformatf("pingpong_wr%0d.empty", i), {31'b0, empty}, 32'd0);
            applyStimulus(1'b1, 1'b0, 1'b1, 32'd0);
            checkOutput($sformatf("pingpong_rd%0d", i), 32'd1 << i, 1'b1, 1'b0);
        end

        // ---------------- overflow ----------------
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 32'd1 << i);
            checkValue($sformatf("fill_wr%0d.full", i), {31'b0, full},
                       (i >= 7) ? 32'd1 : 32'd0);
        end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        checkValue("fill_wr8.overflow", {31'b0, overflow}, 32'd1);
`endif
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 32'd0);
            checkOutput($sformatf("drain_rd%0d", i), 32'd1 << i, (i == 7), 1'b0);
        end

        // ---------------- wrap with simultaneous access ----------------
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 32'd200 + k);
        end
        checkOutput("prefill5", 32'd128, 1'b0, 1'b0);
        for (int k = 0; k < 12; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 32'd205 + k);
            checkOutput($sformatf("simul%0d", k), 32'd200 + k, 1'b0, 1'b0);
        end
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 32'd0);
            checkOutput($sformatf("wrap_drain%0d", k), 32'd212 + k, (k == 4), 1'b0);
        end

        // ---------------- asynchronous reset mid-operation ----------------
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_00AA);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_00BB);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'd0);
        checkOutput("pre_reset_rd", 32'h0000_00AA, 1'b0, 1'b0);
        @(negedge clk);
        cs    = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 32'd0, 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b1, 32'd0);
        checkOutput("post_reset_rd", 32'd0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_0042);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'd0);
        expWord = 32'h0000_0042;
        checkOutput("post_reset_wr_rd", expWord, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
